// File: rtl/inv_sqrt_nr.sv
// Pipelined fixed-point 1/sqrt(x): even-exponent normalise, LUT seed, NR_ITERS Newton-Raphson steps, denormalise.
// Define INV_SQRT_NR_SQRT_OUT_EN to add sqrt_out = x * inv_sqrt behind one extra multiply stage.
module inv_sqrt_nr #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int LUT_BITS = 8,
  parameter int NR_ITERS = 2,
  parameter int TAG_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [WIDTH-1:0] x,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [WIDTH-1:0]        inv_sqrt,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    err_zero,
  output logic                    err_neg,
  output logic                    sat
`ifdef INV_SQRT_NR_SQRT_OUT_EN
  ,
  output logic [WIDTH-1:0]        sqrt_out
`endif
);
  localparam int W   = WIDTH;
  localparam int NST = 3 * NR_ITERS;
  localparam int EW  = $clog2(WIDTH) + 2;
  localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] THREE  = {2'b11, {(W-2){1'b0}}};
  localparam logic [1:0] CLS_OK = 2'd0, CLS_ZERO = 2'd1, CLS_NEG = 2'd2;

  function automatic int lzc(input logic [W-1:0] v);
    int n;
    n = W;
    for (int i = 0; i < W; i++)
      if (v[i]) n = W - 1 - i;
    return n;
  endfunction

  // Seed = floor(2^(W-2) / sqrt(bin midpoint)); bins below 0.25 are never indexed.
  function automatic logic [W-1:0] seed_val(input int idx);
    logic [127:0] num, root, cand;
    int k;
    k = (idx < 2**(LUT_BITS-2)) ? 2**(LUT_BITS-2) : idx;
    num = (128'd1 << (2*(W-2) + LUT_BITS + 1)) / 128'(2*k + 1);
    root = '0;
    for (int b = 63; b >= 0; b--) begin
      cand = root | (128'd1 << b);
      if (cand * cand <= num) root = cand;
    end
    return root[W-1:0];
  endfunction

  function automatic logic [W-1:0] mul_trunc(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[2*W-2 -: W];
  endfunction

  function automatic logic [2*W-1:0] denorm(input logic [W-1:0] y, input logic signed [EW-1:0] e);
    int sh;
    logic [2*W-1:0] wide;
    sh = W - 2 - FRAC + int'(e);
    wide = {{W{1'b0}}, y};
    return (sh >= 0) ? (wide >> sh) : (wide << (-sh));
  endfunction

  function automatic logic is_sat(input logic [2*W-1:0] wide);
    return wide > {{W{1'b0}}, MAXPOS};
  endfunction

  function automatic logic [W-1:0] sat_clip(input logic [2*W-1:0] wide);
    return is_sat(wide) ? MAXPOS : wide[W-1:0];
  endfunction

`ifdef INV_SQRT_NR_SQRT_OUT_EN
  function automatic logic [W-1:0] sqrt_mul(input logic [W-1:0] xv, input logic [2*W-1:0] r);
    logic [3*W-1:0] p;
    p = {{(2*W){1'b0}}, xv} * {{W{1'b0}}, r};
    return p[FRAC +: W];
  endfunction
`endif

  logic [W-1:0] w_rom [0:2**LUT_BITS-1];
  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_rom
    localparam logic [W-1:0] SEED = seed_val(g);
    assign w_rom[g] = SEED;
  end

  logic w_en;
  int w_lz, w_s;
  logic [W-1:0] w_m;
  logic signed [EW-1:0] w_e;
  logic [1:0] w_cls;

  logic                 r_vld_p0;
  logic [W-1:0]         r_m_p0;
  logic signed [EW-1:0] r_e_p0;
  logic [1:0]           r_cls_p0;
  logic [TAG_W-1:0]     r_tag_p0;

  logic [NST:0]         r_vld_pn;
  logic [W-1:0]         r_y_pn   [0:NST];
  logic [W-1:0]         r_m_pn   [0:NST];
  logic [W-1:0]         r_a_pn   [0:NST];
  logic signed [EW-1:0] r_e_pn   [0:NST];
  logic [1:0]           r_cls_pn [0:NST];
  logic [TAG_W-1:0]     r_tag_pn [0:NST];

  logic [2*W-1:0] w_wide;
  logic [W-1:0]   w_res;
  logic           w_ez, w_eng, w_sat;

  logic             r_vld_po, r_ez_po, r_en_po, r_sat_po;
  logic [W-1:0]     r_res_po;
  logic [TAG_W-1:0] r_tag_po;

`ifdef INV_SQRT_NR_SQRT_OUT_EN
  logic [W-1:0]     r_x_p0;
  logic [W-1:0]     r_x_pn [0:NST];
  logic [W-1:0]     r_x_po;
  logic [2*W-1:0]   r_wide_po;
  logic             r_vld_pq, r_ez_pq, r_en_pq, r_sat_pq;
  logic [W-1:0]     r_res_pq, r_sqrt_pq;
  logic [TAG_W-1:0] r_tag_pq;
`endif

  // Stage N: pick an even shift so m lands in [0.25, 1) and x = m * 2^(2e)
  always_comb begin
    w_lz = lzc(x);
    w_s  = (((W - FRAC - w_lz) % 2) == 0) ? w_lz : w_lz - 1;
    if (w_s < 0) w_s = 0;
    w_m   = x << w_s;
    w_e   = EW'((W - FRAC - w_s) / 2);
    w_cls = (x == '0) ? CLS_ZERO : (x[W-1] ? CLS_NEG : CLS_OK);
  end

  // Stage O: undo the exponent, then resolve special classes and saturation
  always_comb begin
    w_wide = denorm(r_y_pn[NST], r_e_pn[NST]);
    w_res  = '0;
    w_ez   = 1'b0;
    w_eng  = 1'b0;
    w_sat  = 1'b0;
    case (r_cls_pn[NST])
      CLS_ZERO: begin w_res = MAXPOS; w_ez = 1'b1; end
      CLS_NEG:  w_eng = 1'b1;
      default:  begin w_sat = is_sat(w_wide); w_res = sat_clip(w_wide); end
    endcase
  end

  assign w_en     = !(valid_out && !ready_out);
  assign ready_in = w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_pn <= '0;
      r_vld_po <= 1'b0;
      r_res_po <= '0;
      r_tag_po <= '0;
      r_ez_po  <= 1'b0;
      r_en_po  <= 1'b0;
      r_sat_po <= 1'b0;
    end else if (w_en) begin
      r_vld_p0    <= valid_in;
      r_vld_pn[0] <= r_vld_p0;
      for (int k = 1; k <= NST; k++) r_vld_pn[k] <= r_vld_pn[k-1];
      r_vld_po <= r_vld_pn[NST];
      if (r_vld_pn[NST]) begin
        r_res_po <= w_res;
        r_tag_po <= r_tag_pn[NST];
        r_ez_po  <= w_ez;
        r_en_po  <= w_eng;
        r_sat_po <= w_sat;
      end
    end
  end

  // Stage S seeds y from the ROM; stage k of the NR chain runs t=y*y, u=m*t, y=y*(3-u)/2 in turn
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_m_p0   <= w_m;
      r_e_p0   <= w_e;
      r_cls_p0 <= w_cls;
      r_tag_p0 <= tag_in;
      r_y_pn[0]   <= w_rom[r_m_p0[W-1 -: LUT_BITS]];
      r_m_pn[0]   <= r_m_p0;
      r_a_pn[0]   <= '0;
      r_e_pn[0]   <= r_e_p0;
      r_cls_pn[0] <= r_cls_p0;
      r_tag_pn[0] <= r_tag_p0;
      for (int k = 1; k <= NST; k++) begin
        r_y_pn[k]   <= r_y_pn[k-1];
        r_m_pn[k]   <= r_m_pn[k-1];
        r_a_pn[k]   <= r_a_pn[k-1];
        r_e_pn[k]   <= r_e_pn[k-1];
        r_cls_pn[k] <= r_cls_pn[k-1];
        r_tag_pn[k] <= r_tag_pn[k-1];
        case ((k - 1) % 3)
          0:       r_a_pn[k] <= mul_trunc(r_y_pn[k-1], r_y_pn[k-1]);
          1:       r_a_pn[k] <= mul_trunc(r_m_pn[k-1], r_a_pn[k-1]);
          default: r_y_pn[k] <= mul_trunc(r_y_pn[k-1], THREE - r_a_pn[k-1]);
        endcase
      end
`ifdef INV_SQRT_NR_SQRT_OUT_EN
      r_x_p0    <= x;
      r_x_pn[0] <= r_x_p0;
      for (int k = 1; k <= NST; k++) r_x_pn[k] <= r_x_pn[k-1];
      if (r_vld_pn[NST]) begin
        r_x_po    <= r_x_pn[NST];
        r_wide_po <= w_wide;
      end
`endif
    end
  end

`ifdef INV_SQRT_NR_SQRT_OUT_EN
  // Stage Q: sqrt from the unclipped reciprocal, everything else delayed to match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pq  <= 1'b0;
      r_res_pq  <= '0;
      r_sqrt_pq <= '0;
      r_tag_pq  <= '0;
      r_ez_pq   <= 1'b0;
      r_en_pq   <= 1'b0;
      r_sat_pq  <= 1'b0;
    end else if (w_en) begin
      r_vld_pq <= r_vld_po;
      if (r_vld_po) begin
        r_res_pq  <= r_res_po;
        r_sqrt_pq <= (r_ez_po || r_en_po) ? '0 : sqrt_mul(r_x_po, r_wide_po);
        r_tag_pq  <= r_tag_po;
        r_ez_pq   <= r_ez_po;
        r_en_pq   <= r_en_po;
        r_sat_pq  <= r_sat_po;
      end
    end
  end

  assign valid_out = r_vld_pq;
  assign inv_sqrt  = r_res_pq;
  assign sqrt_out  = r_sqrt_pq;
  assign tag_out   = r_tag_pq;
  assign err_zero  = r_ez_pq;
  assign err_neg   = r_en_pq;
  assign sat       = r_sat_pq;
`else
  assign valid_out = r_vld_po;
  assign inv_sqrt  = r_res_po;
  assign tag_out   = r_tag_po;
  assign err_zero  = r_ez_po;
  assign err_neg   = r_en_po;
  assign sat       = r_sat_po;
`endif
endmodule

// File: doc/inv_sqrt_nr.md
Name: inv_sqrt_nr

Overview:
- Parametrised, fully pipelined fixed-point reciprocal square root, 1/sqrt(x).
- Successor to the single-stage LUT inverse-sqrt used by the ray marcher's vector normalise path.
- Adds even-exponent normalisation, an LUT seed refined by N Newton-Raphson iterations, and valid/ready back-pressure.
- Adds tag passthrough (ray/lane id), plus zero/negative/saturation flags. Accepts one operand per cycle.

Parameters:
- WIDTH, 32: operand/result word width, signed two's complement.
- FRAC, 24: fractional bits of operand and result (default Q8.24).
- LUT_BITS, 8: mantissa bits indexing the seed ROM (2^LUT_BITS entries).
- NR_ITERS, 2: Newton-Raphson iterations (legal range 0..3).
- TAG_W, 8: width of the sideband tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  operand valid
- ready_in  out  1  block can accept operand this cycle
- x  in  WIDTH  operand, Q(WIDTH-FRAC).FRAC signed
- tag_in  in  TAG_W  sideband, returned unchanged with the result
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- inv_sqrt  out  WIDTH  result, same Q format as x
- tag_out  out  TAG_W  tag aligned with inv_sqrt
- err_zero  out  1  result came from x==0
- err_neg  out  1  result came from x<0
- sat  out  1  result clipped to max positive

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high.
  - While rst is high, every pipeline valid bit is 0.
  - Outputs while in reset: valid_out=0, inv_sqrt=0, tag_out=0, err_zero=0, err_neg=0, sat=0.
  - Reset asserted mid-operation discards all in-flight operands. No output is produced for them.
- Handshake:
  - An operand is accepted when valid_in && ready_in.
  - A result is consumed when valid_out && ready_out.
  - ready_in = !(valid_out && !ready_out). The pipeline uses a single global stall enable, so every stage holds while stalled.
  - While stalled, valid_out, inv_sqrt, tag_out and the flags are held stable.
  - Accepting an input and consuming an output in the same cycle is legal; throughput is 1 per cycle.
- Latency: L = 3 + 3*NR_ITERS cycles from accept to valid_out, excluding stall cycles. With defaults, L = 9.
- Stage N (normalise):
  - Count leading zeros of x.
  - Choose an even shift so that x = m * 2^(2e), with m in [0.25, 1) held as an unsigned WIDTH-bit fraction. e is signed.
  - Register m, e, tag and the special-case class.
- Stage S (seed): ROM indexed by the top LUT_BITS of m. Entry = 1/sqrt of the bin midpoint, as an unsigned fraction in [1, 2] with WIDTH-2 fractional bits.
- NR stages: 3 registered multiplies per iteration.
  - t = y*y, then u = m*t, then y' = y*(3-u)/2.
  - Products are truncated back to internal width.
  - When NR_ITERS = 0, the seed passes straight to the output stage.
- Stage O (denormalise):
  - result = y * 2^(-e), rounded by truncation into Q(WIDTH-FRAC).FRAC.
  - If the result exceeds 2^(WIDTH-1)-1 LSB, output 0x7FF..F and set sat=1.
- Special cases (classified in Stage N, travel down the pipeline with the data):
  - x == 0: inv_sqrt = max positive, err_zero=1, sat=0.
  - x < 0: inv_sqrt = 0, err_neg=1.
  - Flags are valid only while valid_out=1, and are mutually exclusive.
- Accuracy, defaults only: |inv_sqrt - ideal| ≤ 4 LSB, or ≤ 2^-20 relative, whichever is larger. Saturated outputs are excluded.
- Ordering: results emerge strictly in acceptance order. tag_out is bit-exact to the matching tag_in.

Optional Feature:
- Macro: INV_SQRT_NR_SQRT_OUT_EN.
- When defined:
  - Add output port sqrt_out [WIDTH].
  - sqrt_out = x * inv_sqrt, computed in one extra registered multiply stage.
  - Latency becomes L+1, and every output (including inv_sqrt, tag, flags) is delayed to match.
  - Special cases: x==0 gives sqrt_out=0; x<0 gives sqrt_out=0; a saturated inv_sqrt gives sqrt_out computed from the unclipped value.
- When undefined: no sqrt_out port, latency L, and no extra multiplier is inferred.

Test Plan:
- Identity and scaling:
  - x=0x01000000 (1.0), tag=0x11 -> after 9 cycles, inv_sqrt=0x01000000 ±4, tag_out=0x11, no flags.
  - x=0x04000000 -> 0x00800000 ±4.
  - x=0x00400000 -> 0x02000000 ±4.
- Special values:
  - x=0 -> inv_sqrt=0x7FFFFFFF, err_zero=1.
  - x=0x80000000 -> inv_sqrt=0, err_neg=1.
  - x=0x00000001 -> inv_sqrt=0x7FFFFFFF, sat=1.
- Streaming: 64 back-to-back random positive operands with ready_out=1 -> 64 results in order, no bubbles after the first 9 cycles, each within accuracy bound against a real-valued model.
- Back-pressure: stream with ready_out toggled pseudo-randomly (50%) -> ready_in low exactly when valid_out && !ready_out; outputs stable while stalled; no result lost or duplicated; tags in order.
- Reset mid-flight: accept 5 operands, assert rst at cycle 4 for 2 cycles -> valid_out=0 and all outputs 0 during reset; no stale results after release; next operand returns after 9 cycles.
- Feature build with INV_SQRT_NR_SQRT_OUT_EN: x=0x04000000 -> at cycle 10, sqrt_out=0x02000000 ±4 and inv_sqrt=0x00800000 ±4.
